// File: rtl/pong_pkg.sv
// Shared playfield constants, FSM encoding and serve-direction table for the pong
// ball sequencer and its collision detector.
package pong_pkg;

  localparam int WIDTH        = 16;
  localparam int BIT_OF_WIDTH = 4;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SERVE = 3'd1;
  localparam logic [2:0] ST_PLAY  = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_EVAL  = 3'd4;
  localparam logic [2:0] ST_MISS  = 3'd5;

  localparam logic [1:0] SIDE_LEFT   = 2'd0;
  localparam logic [1:0] SIDE_RIGHT  = 2'd1;
  localparam logic [1:0] SIDE_TOP    = 2'd2;
  localparam logic [1:0] SIDE_BOTTOM = 2'd3;

  localparam logic [2*BIT_OF_WIDTH-1:0] CENTRE =
    {BIT_OF_WIDTH'(WIDTH / 2), BIT_OF_WIDTH'(WIDTH / 2)};

  // Direction as sign bits: 1 means the axis steps by -1.
  typedef struct packed {
    logic dx_neg;
    logic dy_neg;
  } dir_t;

  // Serve index rotates the ball through the four diagonals.
  function automatic dir_t serve_dir(input logic [1:0] idx);
    dir_t d;
    case (idx)
      2'd0:    d = '{dx_neg: 1'b0, dy_neg: 1'b0};
      2'd1:    d = '{dx_neg: 1'b1, dy_neg: 1'b0};
      2'd2:    d = '{dx_neg: 1'b1, dy_neg: 1'b1};
      default: d = '{dx_neg: 1'b0, dy_neg: 1'b1};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/ball_seq_serve_timer.sv
// Counts game ticks while the ball rests at centre; done fires combinationally
// on the tick that completes the serve delay and the count restarts from zero.
module serve_timer #(
  parameter int SERVE_TICKS = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam int CW = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(SERVE_TICKS - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] count_reg;

  assign done = en && (count_reg == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clr || done) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= count_reg + ONE;
    end
  end

endmodule

// File: rtl/ball_seq.sv
// Pong ball sequencer: serves from centre, steps the ball on each game tick,
// bounces on paddle hits reported by the detector and flags misses at the edges.
module ball_seq
  import pong_pkg::*;
#(
  parameter int WIDTH        = pong_pkg::WIDTH,
  parameter int BIT_OF_WIDTH = pong_pkg::BIT_OF_WIDTH,
  parameter int SERVE_TICKS  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      tick,
  input  logic [1:0]                collide,
  output logic [2*BIT_OF_WIDTH-1:0] pos,
  output logic                      in_play,
  output logic                      miss,
  output logic [1:0]                miss_side
);

  localparam int BW = BIT_OF_WIDTH;
  localparam logic [BW-1:0] MID     = BW'(WIDTH / 2);
  localparam logic [BW-1:0] EDGE_HI = BW'(WIDTH - 1);
  localparam logic [BW-1:0] ONE     = BW'(1);

  logic [2:0]    state_reg, state_next;
  logic [BW-1:0] x_reg, y_reg;
  logic          dx_neg_reg, dy_neg_reg;
  logic [1:0]    serve_idx_reg;
  logic [1:0]    miss_side_reg;

  logic          serve_done;
  logic          timer_clr;
  logic          timer_en;
  logic          edge_hit;
  logic [1:0]    side_next;
  dir_t          start_dir;
  dir_t          next_dir;

  assign timer_clr = stop || (state_reg != ST_SERVE);
  assign timer_en  = tick && !stop && (state_reg == ST_SERVE);

  serve_timer #(
    .SERVE_TICKS(SERVE_TICKS)
  ) u_serve_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (timer_clr),
    .en   (timer_en),
    .done (serve_done)
  );

  assign start_dir = serve_dir(serve_idx_reg);
  assign next_dir  = serve_dir(serve_idx_reg + 2'd1);

  // Edge priority: left, right, top, bottom, so a corner reports the x side.
  always_comb begin
    edge_hit  = 1'b1;
    side_next = SIDE_LEFT;
    if (x_reg == '0) begin
      side_next = SIDE_LEFT;
    end else if (x_reg == EDGE_HI) begin
      side_next = SIDE_RIGHT;
    end else if (y_reg == '0) begin
      side_next = SIDE_TOP;
    end else if (y_reg == EDGE_HI) begin
      side_next = SIDE_BOTTOM;
    end else begin
      edge_hit = 1'b0;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (stop) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE:  if (start) state_next = ST_SERVE;
        ST_SERVE: if (serve_done) state_next = ST_PLAY;
        ST_PLAY:  if (tick) state_next = ST_WAIT;
        ST_WAIT:  state_next = ST_EVAL;
        ST_EVAL:  state_next = edge_hit ? ST_MISS : ST_PLAY;
        ST_MISS:  state_next = ST_SERVE;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      x_reg         <= MID;
      y_reg         <= MID;
      dx_neg_reg    <= 1'b0;
      dy_neg_reg    <= 1'b0;
      serve_idx_reg <= 2'd0;
      miss_side_reg <= SIDE_LEFT;
    end else begin
      state_reg <= state_next;
      if (stop) begin
        x_reg <= MID;
        y_reg <= MID;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            x_reg <= MID;
            y_reg <= MID;
            if (start) begin
              dx_neg_reg <= start_dir.dx_neg;
              dy_neg_reg <= start_dir.dy_neg;
            end
          end
          ST_PLAY: begin
            if (tick) begin
              x_reg <= dx_neg_reg ? (x_reg - ONE) : (x_reg + ONE);
              y_reg <= dy_neg_reg ? (y_reg - ONE) : (y_reg + ONE);
            end
          end
          ST_EVAL: begin
            if (collide[1]) dy_neg_reg <= ~dy_neg_reg;
            if (collide[0]) dx_neg_reg <= ~dx_neg_reg;
            if (edge_hit) miss_side_reg <= side_next;
          end
          ST_MISS: begin
            x_reg         <= MID;
            y_reg         <= MID;
            serve_idx_reg <= serve_idx_reg + 2'd1;
            dx_neg_reg    <= next_dir.dx_neg;
            dy_neg_reg    <= next_dir.dy_neg;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign pos       = {x_reg, y_reg};
  assign in_play   = (state_reg == ST_PLAY) || (state_reg == ST_WAIT) ||
                     (state_reg == ST_EVAL);
  assign miss      = (state_reg == ST_MISS);
  assign miss_side = miss_side_reg;

endmodule

// File: tb/tb_ball_seq.sv
// Scoreboard bench for ball_seq: stimulus queues the expected observable event,
// a negedge monitor pops and compares whenever pos changes or miss pulses.
module tb_ball_seq;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       stop  = 1'b0;
  logic       tick  = 1'b0;
  logic [1:0] collide = 2'b00;
  logic [7:0] pos;
  logic       in_play;
  logic       miss;
  logic [1:0] miss_side;

  always #5 clk = ~clk;

  ball_seq #(
    .WIDTH       (16),
    .BIT_OF_WIDTH(4),
    .SERVE_TICKS (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .tick     (tick),
    .collide  (collide),
    .pos      (pos),
    .in_play  (in_play),
    .miss     (miss),
    .miss_side(miss_side)
  );

  typedef struct packed {
    logic [7:0] pos;
    logic       miss;
    logic [1:0] side;
    logic       in_play;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        mon_e;
  int         errors = 0;
  int         checks = 0;
  int         ev_n = 0;
  logic [7:0] last_pos = 8'h88;
  logic [1:0] held_side = 2'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      last_pos = pos;
    end else if (pos !== last_pos || miss === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got pos=%h miss=%b, expected no event", pos, miss);
      end else begin
        mon_e = exp_q.pop_front();
        ev_n++;
        $display("event %0d: pos=%h miss=%b side=%0d in_play=%b (exp pos=%h miss=%b side=%0d in_play=%b)",
                 ev_n, pos, miss, miss_side, in_play,
                 mon_e.pos, mon_e.miss, mon_e.side, mon_e.in_play);
        check("ev_pos", 32'(pos), 32'(mon_e.pos));
        check("ev_miss", 32'(miss), 32'(mon_e.miss));
        check("ev_miss_side", 32'(miss_side), 32'(mon_e.side));
        check("ev_in_play", 32'(in_play), 32'(mon_e.in_play));
      end
      last_pos = pos;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input logic [7:0] p, input logic m, input logic [1:0] s, input logic ip);
    ev_t e;
    e.pos = p;
    e.miss = m;
    e.side = s;
    e.in_play = ip;
    exp_q.push_back(e);
  endtask

  task automatic tick_pulse();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    cyc();
  endtask

  task automatic serve_ticks();
    repeat (8) tick_pulse();
  endtask

  // One PLAY tick: ball moves (WAIT), then collide is presented during EVAL.
  task automatic play_step(input logic [7:0] p, input logic [1:0] col);
    expect_ev(p, 1'b0, held_side, 1'b1);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    cyc();
    collide = col;
    cyc();
    collide = 2'b00;
  endtask

  // Called while in MISS: the pulse shows the edge cell, then pos returns to centre.
  task automatic miss_step(input logic [7:0] p, input logic [1:0] side);
    held_side = side;
    expect_ev(p, 1'b1, side, 1'b0);
    expect_ev(8'h88, 1'b0, side, 1'b0);
    cyc();
  endtask

  initial begin
    logic [7:0] game_a [12];
    logic [1:0] col_a  [12];
    logic [7:0] game_b [7];
    logic [7:0] game_c [8];
    game_a = '{8'h99, 8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h24, 8'h15, 8'h26, 8'h17, 8'h08};
    col_a  = '{2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00};
    game_b = '{8'h79, 8'h6A, 8'h5B, 8'h4C, 8'h3D, 8'h2E, 8'h1F};
    game_c = '{8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11, 8'h00};

    #1 rst_n = 1'b0;
    #1;
    check("reset_pos", 32'(pos), 32'h88);
    check("reset_miss", 32'(miss), 32'h0);
    check("reset_miss_side", 32'(miss_side), 32'h0);
    check("reset_in_play", 32'(in_play), 32'h0);
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();

    // Game A: serve (+,+), double bounce, steer to {1,5}, bounce x, miss left at {0,8}.
    start = 1'b1;
    cyc();
    start = 1'b0;
    serve_ticks();
    play_step(game_a[0], col_a[0]);
    check("in_play_after_eval", 32'(in_play), 32'h1);
    for (int i = 1; i < 12; i++) play_step(game_a[i], col_a[i]);
    miss_step(8'h08, 2'd0);

    // Game B: serve index 1 (-,+), runs into bottom edge at {1,15}.
    serve_ticks();
    for (int i = 0; i < 7; i++) play_step(game_b[i], 2'b00);
    miss_step(8'h1F, 2'd3);

    // Game C: serve index 2 (-,-), reaches corner {0,0}; left wins over top.
    serve_ticks();
    for (int i = 0; i < 8; i++) play_step(game_c[i], 2'b00);
    miss_step(8'h00, 2'd0);

    // Game D: serve index 3 (+,-), stop asserted while in WAIT.
    serve_ticks();
    expect_ev(8'h97, 1'b0, held_side, 1'b1);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    stop = 1'b1;
    expect_ev(8'h88, 1'b0, held_side, 1'b0);
    cyc();
    stop = 1'b0;
    check("in_play_after_stop", 32'(in_play), 32'h0);

    // start and stop together in IDLE: ticks afterwards must not launch a ball.
    start = 1'b1;
    stop  = 1'b1;
    cyc();
    start = 1'b0;
    stop  = 1'b0;
    repeat (10) tick_pulse();
    check("in_play_start_stop", 32'(in_play), 32'h0);

    // Async reset in the middle of SERVE, then a fresh game from index 0.
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (3) tick_pulse();
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_pos", 32'(pos), 32'h88);
    check("async_reset_miss", 32'(miss), 32'h0);
    check("async_reset_miss_side", 32'(miss_side), 32'h0);
    check("async_reset_in_play", 32'(in_play), 32'h0);
    cyc();
    rst_n = 1'b1;
    held_side = 2'd0;
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    serve_ticks();
    play_step(8'h99, 2'b00);
    check("in_play_restart", 32'(in_play), 32'h1);

    repeat (4) cyc();
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ball_seq.md
BALL_SEQ -- requirements
Module: ball_seq

Interface
REQ-001 Parameter WIDTH, default 16, playfield size in cells per axis.
REQ-002 Parameter BIT_OF_WIDTH, default 4, coordinate width.
REQ-003 Parameter SERVE_TICKS, default 8, ticks the ball rests at centre before play.
REQ-004 clk  in  1  single system clock, all logic on posedge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  level; begins a game from IDLE.
REQ-007 stop  in  1  level; aborts to IDLE from any state.
REQ-008 tick  in  1  one-cycle game-step strobe.
REQ-009 collide  in  2  from collision detector: bit1 = top/bottom paddle hit, bit0 = left/right paddle hit.
REQ-010 pos  out  2*BIT_OF_WIDTH  ball position {x,y}, x in upper half; feeds detector.
REQ-011 in_play  out  1  high in PLAY, WAIT and EVAL.
REQ-012 miss  out  1  one-cycle pulse on a missed ball.
REQ-013 miss_side  out  2  0 left, 1 right, 2 top, 3 bottom; valid while miss high, else holds.

Function
REQ-014 FSM states: IDLE, SERVE, PLAY, WAIT, EVAL, MISS; one-hot or binary, encoding from package.
REQ-015 IDLE: pos = centre {8,8}; start=1 -> SERVE next cycle.
REQ-016 SERVE: pos held at centre; serve counter increments per tick; on tick with count == SERVE_TICKS-1 -> PLAY, counter cleared.
REQ-017 PLAY: on tick, pos <= {x+dx, y+dy}, dx/dy each +1 or -1 (1-bit sign regs), -> WAIT; no tick -> stay.
REQ-018 WAIT: one cycle, unconditional -> EVAL (covers registered detector latency).
REQ-019 EVAL: collide sampled this cycle only; bit1 -> dy negated; bit0 -> dx negated; both may flip together.
REQ-020 EVAL miss check on current pos, priority left(x==0), right(x==WIDTH-1), top(y==0), bottom(y==WIDTH-1); any hit -> MISS with miss_side, else -> PLAY.
REQ-021 MISS: miss=1 for exactly this cycle; pos <= centre; serve direction index (2-bit) advances; -> SERVE.
REQ-022 Serve direction index 0..3 maps dx,dy to (+,+),(-,+),(-,-),(+,-); wraps 3->0; applied on entry to SERVE.
REQ-023 Coordinate add is modulo 2^BIT_OF_WIDTH but wrap is unreachable: miss terminates play at edge cells.
REQ-024 tick outside PLAY/SERVE ignored, not queued; tick in WAIT/EVAL/MISS dropped.
REQ-025 stop has priority over every transition: next cycle IDLE, pos centre, counter cleared, miss 0; start while not IDLE ignored.
REQ-026 start and stop both high in IDLE: remain IDLE.

Reset
REQ-027 rst_n low: state IDLE, pos 8'h88, dx=+1, dy=+1, serve index 0, serve counter 0, miss 0, miss_side 0, in_play 0; outputs valid immediately (async).
REQ-028 Reset deassertion mid-game needs no recovery: block restarts from IDLE, start required.

Structure
REQ-029 Shared package pong_pkg holds WIDTH, BIT_OF_WIDTH, state encoding, side codes, centre constant; the collision detector uses the same package.
REQ-030 One natural sub-module: serve_timer (tick counter, SERVE_TICKS compare, done pulse); all else in one always block plus next-state logic.

Verification
REQ-031 Reset, start=1, 8 ticks -> PLAY; next tick pos 8'h99; WAIT, EVAL, PLAY; in_play=1.
REQ-032 Ball at {1,5}, dx=-1, collide=2'b01 in EVAL -> dx=+1; next tick pos {2,6}; no miss.
REQ-033 Ball reaches x=0 with collide=0 -> miss=1 for one cycle, miss_side=0, pos 8'h88, serve index 1, dx=-1,dy=+1 at next play.
REQ-034 pos reaches {0,0} corner -> miss_side=0 (left priority over top).
REQ-035 collide=2'b11 in EVAL -> both dx and dy negated same cycle.
REQ-036 stop asserted in WAIT -> IDLE next cycle, pos 8'h88, no miss pulse; rst_n pulse during SERVE -> all REQ-027 values asynchronously.
